// File: rtl/alu_regfile_datapath.sv
// Execution datapath: 8-entry register file, operand-B select, 4-op ALU and ZERO flag.
// Define ALU_REGFILE_SIM_DELAY_EN to add simulation-only timing annotations to every path.
`ifdef ALU_REGFILE_SIM_DELAY_EN
`define ALU_RF_DLY1 #1
`define ALU_RF_DLY2 #2
`else
`define ALU_RF_DLY1
`define ALU_RF_DLY2
`endif

module alu_regfile_datapath #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WRITEENABLE,
    input  logic [ADDR_W-1:0] WRITEREG,
    input  logic [ADDR_W-1:0] READREG1,
    input  logic [ADDR_W-1:0] READREG2,
    input  logic [DATA_W-1:0] IMMVAL,
    input  logic [2:0]        ALUOP,
    input  logic              SIGN,
    input  logic              IMMEDIATE,
    output logic [DATA_W-1:0] REGOUT1,
    output logic [DATA_W-1:0] REGOUT2,
    output logic [DATA_W-1:0] ALURESULT,
    output logic              ZERO
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        OpForward = 3'b000,
        OpAdd     = 3'b001,
        OpAnd     = 3'b010,
        OpOr      = 3'b011
    } alu_op_e;

    logic [DATA_W-1:0] regs_q [NumRegs];
    logic [DATA_W-1:0] neg_b;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] fwd_res;
    logic [DATA_W-1:0] add_res;
    logic [DATA_W-1:0] and_res;
    logic [DATA_W-1:0] or_res;
    logic [DATA_W-1:0] alu_res;

    // Reset wins over write-back; the write samples ALURESULT at the edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            regs_q <= `ALU_RF_DLY1 '{default: '0};
        end else if (WRITEENABLE) begin
            regs_q[WRITEREG] <= `ALU_RF_DLY1 ALURESULT;
        end
    end

    // No write bypass: a read sees the old contents until the edge.
    assign `ALU_RF_DLY2 REGOUT1 = regs_q[READREG1];
    assign `ALU_RF_DLY2 REGOUT2 = regs_q[READREG2];

    assign `ALU_RF_DLY1 neg_b = ~REGOUT2 + 1'b1;

    assign op_a = REGOUT1;
    assign op_b = IMMEDIATE ? IMMVAL : (SIGN ? neg_b : REGOUT2);

    assign `ALU_RF_DLY1 fwd_res = op_b;
    assign `ALU_RF_DLY2 add_res = op_a + op_b;
    assign `ALU_RF_DLY1 and_res = op_a & op_b;
    assign `ALU_RF_DLY1 or_res  = op_a | op_b;

    // Reserved opcodes produce zero, which also raises ZERO.
    always_comb begin
        alu_res = '0;
        case (ALUOP)
            OpForward: alu_res = fwd_res;
            OpAdd:     alu_res = add_res;
            OpAnd:     alu_res = and_res;
            OpOr:      alu_res = or_res;
            default:   alu_res = '0;
        endcase
    end

    assign ALURESULT = alu_res;
    assign ZERO      = (ALURESULT == '0);

endmodule

`undef ALU_RF_DLY1
`undef ALU_RF_DLY2

// File: tb/tb_alu_regfile_datapath.sv
// Self-checking bench for alu_regfile_datapath: directed plan followed by random instructions
// checked against an array-based reference model.
module tb_alu_regfile_datapath;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       WRITEENABLE;
    logic [2:0] WRITEREG;
    logic [2:0] READREG1;
    logic [2:0] READREG2;
    logic [7:0] IMMVAL;
    logic [2:0] ALUOP;
    logic       SIGN;
    logic       IMMEDIATE;
    logic [7:0] REGOUT1;
    logic [7:0] REGOUT2;
    logic [7:0] ALURESULT;
    logic       ZERO;

    int n_cmp = 0;
    int n_err = 0;
    int model_regs [8];

    alu_regfile_datapath #(
        .DATA_W(8),
        .ADDR_W(3)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .WRITEENABLE(WRITEENABLE),
        .WRITEREG   (WRITEREG),
        .READREG1   (READREG1),
        .READREG2   (READREG2),
        .IMMVAL     (IMMVAL),
        .ALUOP      (ALUOP),
        .SIGN       (SIGN),
        .IMMEDIATE  (IMMEDIATE),
        .REGOUT1    (REGOUT1),
        .REGOUT2    (REGOUT2),
        .ALURESULT  (ALURESULT),
        .ZERO       (ZERO)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int alu_model(input int a, input int r2, input int imm, input int op,
                                     input bit sg, input bit im);
        int b;
        if (im)      b = imm;
        else if (sg) b = (256 - r2) % 256;
        else         b = r2;
        case (op)
            0:       return b;
            1:       return (a + b) % 256;
            2:       return a & b;
            3:       return a | b;
            default: return 0;
        endcase
    endfunction

    // Called in the low phase; checks combinational outputs, clocks once, updates the model.
    task automatic do_op(input bit rst, input bit we, input int wr, input int r1, input int r2,
                         input int imm, input int op, input bit sg, input bit im,
                         input int exp_res);
        int res;
        logic [7:0] v;
        RESET = rst;
        WRITEENABLE = we;
        v = wr[7:0];  WRITEREG = v[2:0];
        v = r1[7:0];  READREG1 = v[2:0];
        v = r2[7:0];  READREG2 = v[2:0];
        v = imm[7:0]; IMMVAL = v;
        v = op[7:0];  ALUOP = v[2:0];
        SIGN = sg;
        IMMEDIATE = im;
        #2;
        res = alu_model(model_regs[r1], model_regs[r2], imm, op, sg, im);
        check_eq("regout1", int'(REGOUT1), model_regs[r1]);
        check_eq("regout2", int'(REGOUT2), model_regs[r2]);
        check_eq("aluresult", int'(ALURESULT), res);
        check_eq("zero", int'(ZERO), (res == 0) ? 1 : 0);
        if (exp_res >= 0) check_eq("alu_const", int'(ALURESULT), exp_res);
        @(posedge CLK);
        if (rst) begin
            foreach (model_regs[i]) model_regs[i] = 0;
        end else if (we) begin
            model_regs[wr] = res;
        end
        #1;
        check_eq("after_edge_r1", int'(REGOUT1), model_regs[r1]);
        @(negedge CLK);
    endtask

    task automatic check_all(input string tag);
        RESET = 1'b0;
        WRITEENABLE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            READREG1 = 3'(i);
            READREG2 = 3'(i + 4);
            #1;
            check_eq(tag, int'(REGOUT1), model_regs[i]);
            check_eq(tag, int'(REGOUT2), model_regs[i + 4]);
        end
        @(negedge CLK);
    endtask

    initial begin
        RESET = 1'b1; WRITEENABLE = 1'b0; WRITEREG = '0; READREG1 = '0; READREG2 = '0;
        IMMVAL = '0; ALUOP = '0; SIGN = 1'b0; IMMEDIATE = 1'b0;
        @(posedge CLK);
        foreach (model_regs[i]) model_regs[i] = 0;
        @(negedge CLK);

        // 1: reset then loadi
        do_op(1, 0, 0, 0, 0, 0, 0, 0, 0, -1);
        check_all("reset_regs");
        check_eq("reset_r0_const", int'(REGOUT1), 0);
        do_op(0, 1, 4, 0, 0, 5, 0, 0, 1, 5);
        do_op(0, 1, 2, 4, 0, 9, 0, 0, 1, 9);
        do_op(0, 0, 0, 4, 2, 0, 0, 0, 0, -1);
        check_eq("r4_const", int'(REGOUT1), 5);

        // 2: add and wrap-around
        do_op(0, 1, 6, 2, 4, 0, 1, 0, 0, 14);
        do_op(0, 0, 0, 6, 6, 0, 0, 0, 0, 14);
        do_op(0, 1, 1, 0, 0, 200, 0, 0, 1, 200);
        do_op(0, 1, 2, 0, 0, 100, 0, 0, 1, 100);
        do_op(0, 1, 0, 1, 2, 0, 1, 0, 0, 44);

        // 3: sub/beq, no write-back
        do_op(0, 1, 1, 0, 0, 5, 0, 0, 1, 5);
        do_op(0, 1, 4, 0, 0, 5, 0, 0, 1, 5);
        do_op(0, 0, 0, 1, 4, 0, 1, 1, 0, 0);
        do_op(0, 1, 4, 0, 0, 7, 0, 0, 1, 7);
        do_op(0, 0, 0, 1, 4, 0, 1, 1, 0, 8'hFE);
        check_all("sub_no_write");

        // 4: AND / OR / MOV / immediate overrides sign
        do_op(0, 1, 3, 0, 0, 8'hF0, 0, 0, 1, 8'hF0);
        do_op(0, 1, 5, 0, 0, 8'h3C, 0, 0, 1, 8'h3C);
        do_op(0, 0, 0, 3, 5, 0, 2, 0, 0, 8'h30);
        do_op(0, 0, 0, 3, 5, 0, 3, 0, 0, 8'hFC);
        do_op(0, 1, 7, 0, 5, 0, 0, 0, 0, 8'h3C);
        do_op(0, 0, 0, 7, 5, 8'h11, 0, 1, 1, 8'h11);
        do_op(0, 0, 0, 0, 0, 0, 0, 0, 0, -1);

        // 5: write gating, reset priority, read-during-write
        repeat (3) do_op(0, 0, 3, 3, 0, 8'h77, 0, 0, 1, 8'h77);
        check_all("we_gated");
        do_op(0, 1, 6, 6, 0, 8'h42, 0, 0, 1, 8'h42);
        do_op(1, 1, 5, 0, 0, 8'h55, 0, 0, 1, 8'h55);
        check_all("reset_priority");

        // 6: reserved opcode writes zero
        do_op(0, 1, 3, 0, 0, 8'hA5, 0, 0, 1, 8'hA5);
        do_op(0, 1, 3, 3, 3, 8'h12, 5, 0, 0, 0);
        do_op(0, 0, 0, 3, 3, 0, 0, 0, 0, -1);

        // Random instruction stream
        for (int i = 0; i < 300; i++) begin
            do_op(($urandom_range(0, 31) == 0), 1'($urandom), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255),
                  $urandom_range(0, 7), 1'($urandom), ($urandom_range(0, 3) == 0), -1);
        end
        check_all("final_regs");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
